// File: rtl/sensor_link_pkg.sv
// Shared types and constants for the sensor UART link master.
package sensor_link_pkg;

  localparam int unsigned StateW = 3;
  localparam int unsigned CntW   = 16;

  localparam logic [7:0] DefaultStartCode = 8'h00;

  typedef enum logic [StateW-1:0] {
    StIdle    = 3'd0,
    StSendCmd = 3'd1,
    StWaitB0  = 3'd2,
    StWaitB1  = 3'd3,
    StDone    = 3'd4
  } link_state_e;

endpackage

// File: rtl/sensor_link_master_timer.sv
// Response-wait watchdog for sensor_link_master; only built with RESP_TIMEOUT_EN.
`ifdef RESP_TIMEOUT_EN
module link_resp_timer
  import sensor_link_pkg::*;
#(
  parameter logic [CntW-1:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CntW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = enable && (count_q == TIMEOUT_CYCLES - 1'b1);

endmodule
`endif

// File: rtl/sensor_link_master.sv
// Host-side initiator: sends the start code, reassembles the two-byte sensor sum.
// Optional response timeout is enabled by defining RESP_TIMEOUT_EN.
module sensor_link_master
  import sensor_link_pkg::*;
#(
  parameter logic [7:0]      START_CODE     = DefaultStartCode,
  parameter logic [CntW-1:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        tx_busy,
  output logic        tx_send,
  output logic [7:0]  tx_data,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        busy,
  output logic [15:0] data,
  output logic        data_valid,
  output logic        timeout
);

  link_state_e state_q;
  logic [7:0]  low_byte_q;
  logic [15:0] data_q;
  logic        data_valid_q;

`ifdef RESP_TIMEOUT_EN
  logic timeout_q;
  logic in_wait;
  logic expired;

  assign in_wait = (state_q == StWaitB0) || (state_q == StWaitB1);

  // Counter restarts on every state change, so clear on any exit from a wait state.
  link_resp_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_wait || rx_ready || expired),
    .enable (in_wait),
    .expired(expired)
  );

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      low_byte_q   <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
`ifdef RESP_TIMEOUT_EN
      timeout_q    <= 1'b0;
`endif
    end else begin
      data_valid_q <= 1'b0;
`ifdef RESP_TIMEOUT_EN
      timeout_q    <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (req) state_q <= StSendCmd;
        end
        StSendCmd: begin
          if (!tx_busy) state_q <= StWaitB0;
        end
        StWaitB0: begin
          if (rx_ready) begin
            low_byte_q <= rx_data;
            state_q    <= StWaitB1;
          end
`ifdef RESP_TIMEOUT_EN
          else if (expired) begin
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end
`endif
        end
        StWaitB1: begin
          if (rx_ready) begin
            data_q       <= {rx_data, low_byte_q};
            data_valid_q <= 1'b1;
            state_q      <= StDone;
          end
`ifdef RESP_TIMEOUT_EN
          else if (expired) begin
            low_byte_q <= '0;
            timeout_q  <= 1'b1;
            state_q    <= StIdle;
          end
`endif
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign tx_send    = (state_q == StSendCmd) && !tx_busy;
  assign tx_data    = START_CODE;
  assign busy       = (state_q != StIdle);
  assign data       = data_q;
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_sensor_link_master.sv
// Self-checking bench for sensor_link_master: transaction-level model plus directed checks.
module tb_sensor_link_master;

  localparam int unsigned ToCycles = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        tx_busy = 1'b0;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        busy;
  logic [15:0] data;
  logic        data_valid;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int send_cnt = 0;

  always #5 clk = ~clk;

  sensor_link_master #(
    .START_CODE    (8'h00),
    .TIMEOUT_CYCLES(16'd100)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .tx_busy   (tx_busy),
    .tx_send   (tx_send),
    .tx_data   (tx_data),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .busy      (busy),
    .data      (data),
    .data_valid(data_valid),
    .timeout   (timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a transaction is active, may still owe the start code,
  // and has collected 0 or 1 bytes; each byte gets its own wait budget.
  bit          model_ok = 1'b0;
  bit          m_active, m_cmd_pending, m_done, m_to;
  int          m_bytes, m_wait;
  logic [7:0]  m_lo;
  logic [15:0] m_data;

  always @(posedge clk) begin
    bit was_done;
    if (reset) begin
      m_active = 0; m_cmd_pending = 0; m_done = 0; m_to = 0;
      m_bytes = 0; m_wait = 0; m_lo = 8'h00; m_data = 16'h0000;
      model_ok = 1'b1;
    end else begin
      was_done = m_done;
      m_done = 0;
      m_to = 0;
      if (was_done) begin
        // completion cycle: requests are ignored
      end else if (!m_active) begin
        if (req) begin
          m_active = 1; m_cmd_pending = 1; m_bytes = 0; m_wait = 0;
        end
      end else if (m_cmd_pending) begin
        if (!tx_busy) begin
          m_cmd_pending = 0; m_wait = 0;
        end
      end else if (rx_ready) begin
        if (m_bytes == 0) begin
          m_lo = rx_data; m_bytes = 1; m_wait = 0;
        end else begin
          m_data = {rx_data, m_lo}; m_active = 0; m_done = 1;
        end
      end
`ifdef RESP_TIMEOUT_EN
      else if (m_wait == ToCycles - 1) begin
        m_active = 0; m_to = 1; m_bytes = 0;
      end
`endif
      else begin
        m_wait++;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("busy", 32'(busy), 32'(m_active || m_done));
      check("tx_send", 32'(tx_send), 32'(m_active && m_cmd_pending && !tx_busy));
      check("tx_data", 32'(tx_data), 32'h00);
      check("data", 32'(data), 32'(m_data));
      check("data_valid", 32'(data_valid), 32'(m_done));
      check("timeout", 32'(timeout), 32'(m_to));
    end
  end

  always @(posedge clk) if (!reset && tx_send) send_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_ready = 1'b1;
    rx_data  = b;
    tick();
    rx_ready = 1'b0;
  endtask

  // From IDLE with tx_busy low: leaves the DUT in WAIT_B0.
  task automatic start_txn();
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
  endtask

  initial begin
    int base;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_data", 32'(data), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    check("rst_tx_send", 32'(tx_send), 32'h0);
    reset = 1'b0;
    tick();

    // Normal transaction
    req = 1'b1;
    tick();
    check("t1_tx_send", 32'(tx_send), 32'h1);
    check("t1_tx_data", 32'(tx_data), 32'h00);
    req = 1'b0;
    tick();
    check("t1_tx_send_low", 32'(tx_send), 32'h0);
    check("t1_busy", 32'(busy), 32'h1);
    send_byte(8'h34);
    tick();
    tick();
    send_byte(8'h12);
    check("t1_valid", 32'(data_valid), 32'h1);
    check("t1_data", 32'(data), 32'h1234);
    tick();
    check("t1_busy_after", 32'(busy), 32'h0);
    check("t1_valid_after", 32'(data_valid), 32'h0);

    // Transmitter busy for 20 cycles
    base = send_cnt;
    tx_busy = 1'b1;
    req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("t2_tx_send_held", 32'(tx_send), 32'h0);
      tick();
    end
    tx_busy = 1'b0;
    #1;
    check("t2_tx_send_first", 32'(tx_send), 32'h1);
    tick();
    check("t2_tx_send_once", 32'(send_cnt - base), 32'h1);
    send_byte(8'h78);
    send_byte(8'h56);
    check("t2_data", 32'(data), 32'h5678);
    tick();

    // Unsolicited bytes in IDLE and SEND_CMD
    send_byte(8'h99);
    check("t3_idle_busy", 32'(busy), 32'h0);
    check("t3_idle_data", 32'(data), 32'h5678);
    tx_busy = 1'b1;
    req = 1'b1;
    tick();
    req = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    check("t3_cmd_busy", 32'(busy), 32'h1);
    check("t3_cmd_valid", 32'(data_valid), 32'h0);
    tx_busy = 1'b0;
    tick();
    send_byte(8'hCD);
    send_byte(8'hAB);
    check("t3_valid", 32'(data_valid), 32'h1);
    check("t3_data", 32'(data), 32'hABCD);
    tick();

`ifdef RESP_TIMEOUT_EN
    // Timeout in WAIT_B1
    start_txn();
    send_byte(8'h55);
    for (int i = 0; i < 99; i++) tick();
    check("t4_no_early_timeout", 32'(timeout), 32'h0);
    check("t4_busy_before", 32'(busy), 32'h1);
    tick();
    check("t4_timeout", 32'(timeout), 32'h1);
    check("t4_busy", 32'(busy), 32'h0);
    check("t4_data_kept", 32'(data), 32'hABCD);
    tick();
    check("t4_timeout_pulse", 32'(timeout), 32'h0);
    start_txn();
    send_byte(8'h02);
    send_byte(8'h01);
    check("t4_retry_data", 32'(data), 32'h0102);
    tick();

    // rx_ready in the expiry cycle wins
    start_txn();
    send_byte(8'h66);
    for (int i = 0; i < 99; i++) tick();
    send_byte(8'h77);
    check("t5_valid", 32'(data_valid), 32'h1);
    check("t5_no_timeout", 32'(timeout), 32'h0);
    check("t5_data", 32'(data), 32'h7766);
    tick();
`else
    // No timeout: wait states block until the byte arrives
    start_txn();
    send_byte(8'h21);
    for (int i = 0; i < 2000; i++) tick();
    check("t6_busy_held", 32'(busy), 32'h1);
    check("t6_no_timeout", 32'(timeout), 32'h0);
    send_byte(8'h43);
    check("t6_valid", 32'(data_valid), 32'h1);
    check("t6_data", 32'(data), 32'h4321);
    tick();
`endif

    // Reset in WAIT_B1
    start_txn();
    send_byte(8'h11);
    reset = 1'b1;
    tick();
    check("t7_busy", 32'(busy), 32'h0);
    check("t7_data", 32'(data), 32'h0);
    check("t7_valid", 32'(data_valid), 32'h0);
    check("t7_timeout", 32'(timeout), 32'h0);
    reset = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
